// File: rtl/uart_rx_core_cfg.sv
// uart_rx_core_cfg: runtime-configurable UART receiver with
// majority-vote sampling, parity/stop checks and break detection.
module uart_rx_core_cfg #(
  parameter int DATA_W      = 9,
  parameter int PRESC_W     = 6,
  parameter int SYNC_STAGES = 2,
  parameter int LEN_W       = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic [LEN_W-1:0]   DATA_LEN,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic               STOP2,
  output logic [DATA_W-1:0]  P_DATA,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err,
  output logic               brk_det,
  output logic               busy
);
  localparam int BIT_W = LEN_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY,
    S_STOP1, S_STOP2, S_BREAK
  } state_t;

  state_t             state, state_n;
  logic               rx_s;
  logic [PRESC_W-1:0] p_in, p_l, mid, edge_cnt;
  logic [LEN_W-1:0]   len_in, len_l;
  logic               par_en_l, par_typ_l, stop2_l;
  logic [BIT_W-1:0]   bit_idx;
  logic [DATA_W-1:0]  shreg;
  logic               s0, s1, vote;
  logic               pe_q, par_bit_q;
  logic               bit_end, vote_cyc, start, fin;
  logic               dv_n, pe_n, se_n, bk_n;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign rx_s = RX_IN;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      // synchronise the asynchronous line, idle-high after reset
      always_ff @(posedge CLK) begin
        if (RST) sync_q <= '1;
        else     sync_q <= (sync_q << 1) | SYNC_STAGES'(RX_IN);
      end
      assign rx_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // clamp the runtime config to legal frame formats
  always_comb begin
    p_in = {Prescale[PRESC_W-1:1], 1'b0};
    if (p_in < PRESC_W'(6)) p_in = PRESC_W'(6);
    len_in = DATA_LEN;
    if (DATA_LEN < LEN_W'(5))
      len_in = LEN_W'(5);
    else if (DATA_LEN > LEN_W'(DATA_W))
      len_in = LEN_W'(DATA_W);
  end

  assign mid      = p_l >> 1;
  assign bit_end  = (edge_cnt == p_l - PRESC_W'(1));
  assign vote_cyc = (edge_cnt == mid + PRESC_W'(1));
  assign vote     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign start    = (state == S_IDLE) && !rx_s;

  // next-state and one-cycle result strobes
  always_comb begin
    state_n = state;
    fin     = 1'b0;
    dv_n    = 1'b0;
    pe_n    = 1'b0;
    se_n    = 1'b0;
    bk_n    = 1'b0;
    case (state)
      S_IDLE:
        if (!rx_s) state_n = S_START;
      S_START:
        if (vote_cyc && vote) state_n = S_IDLE;
        else if (bit_end)     state_n = S_DATA;
      S_DATA:
        if (bit_end && bit_idx == BIT_W'(len_l))
          state_n = par_en_l ? S_PARITY : S_STOP1;
      S_PARITY:
        if (bit_end) state_n = S_STOP1;
      S_STOP1:
        if (vote_cyc) begin
          if (!(stop2_l && vote)) fin = 1'b1;
        end else if (bit_end && stop2_l) begin
          state_n = S_STOP2;
        end
      S_STOP2:
        if (vote_cyc) fin = 1'b1;
      S_BREAK:
        if (rx_s) state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
    if (fin) begin
      state_n = S_IDLE;
      if (vote) begin
        if (pe_q) pe_n = 1'b1;
        else      dv_n = 1'b1;
      end else if (shreg == '0 && !(par_en_l && par_bit_q)) begin
        bk_n    = 1'b1;
        state_n = S_BREAK;
      end else begin
        se_n = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_n;
  end

  // counters, sampler, deserializer, config latch and outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      p_l        <= PRESC_W'(6);
      len_l      <= LEN_W'(5);
      par_en_l   <= 1'b0;
      par_typ_l  <= 1'b0;
      stop2_l    <= 1'b0;
      edge_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      s0         <= 1'b0;
      s1         <= 1'b0;
      pe_q       <= 1'b0;
      par_bit_q  <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      brk_det    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= dv_n;
      par_err    <= pe_n;
      stp_err    <= se_n;
      brk_det    <= bk_n;
      busy       <= (state_n != S_IDLE);
      if (dv_n) P_DATA <= shreg;
      if (edge_cnt == mid - PRESC_W'(1)) s0 <= rx_s;
      if (edge_cnt == mid)               s1 <= rx_s;
      if (start) begin
        p_l       <= p_in;
        len_l     <= len_in;
        par_en_l  <= PAR_EN;
        par_typ_l <= PAR_TYP;
        stop2_l   <= STOP2;
        edge_cnt  <= '0;
        bit_idx   <= '0;
        shreg     <= '0;
        pe_q      <= 1'b0;
        par_bit_q <= 1'b0;
      end else if (state != S_IDLE && state != S_BREAK) begin
        if (bit_end) begin
          edge_cnt <= '0;
          bit_idx  <= bit_idx + BIT_W'(1);
        end else begin
          edge_cnt <= edge_cnt + PRESC_W'(1);
        end
      end
      if (state == S_DATA && vote_cyc) begin
        for (int i = 0; i < DATA_W; i++)
          if (bit_idx == BIT_W'(i + 1)) shreg[i] <= vote;
      end
      if (state == S_PARITY && vote_cyc) begin
        par_bit_q <= vote;
        if (vote != ((^shreg) ^ par_typ_l)) pe_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core_cfg.sv
// tb_uart_rx_core_cfg: random frames against a frame-level model,
// plus latency, glitch, parity, break and mid-frame reset cases.
`timescale 1ns/1ps
module tb_uart_rx_core_cfg;
  localparam int DATA_W  = 9;
  localparam int PRESC_W = 6;
  localparam int LEN_W   = 4;
  localparam int SYNC    = 2;
  localparam logic [3:0] K_DV = 4'b0001;
  localparam logic [3:0] K_PE = 4'b0010;
  localparam logic [3:0] K_SE = 4'b0100;
  localparam logic [3:0] K_BK = 4'b1000;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               RX_IN = 1'b1;
  logic [PRESC_W-1:0] Prescale = 6'd8;
  logic [LEN_W-1:0]   DATA_LEN = 4'd8;
  logic               PAR_EN = 1'b0;
  logic               PAR_TYP = 1'b0;
  logic               STOP2 = 1'b0;
  logic [DATA_W-1:0]  P_DATA;
  logic               data_valid, par_err;
  logic               stp_err, brk_det, busy;

  uart_rx_core_cfg #(
    .DATA_W(DATA_W), .PRESC_W(PRESC_W),
    .SYNC_STAGES(SYNC), .LEN_W(LEN_W)
  ) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN),
    .Prescale(Prescale), .DATA_LEN(DATA_LEN),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .P_DATA(P_DATA), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err),
    .brk_det(brk_det), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tot = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  int                act_cyc[$];
  logic [3:0]        act_k[$];
  logic [DATA_W-1:0] act_d[$];
  int                exp_cyc[$];
  logic [3:0]        exp_k[$];
  logic [DATA_W-1:0] exp_d[$];

  always @(negedge CLK) begin
    if (data_valid | par_err | stp_err | brk_det) begin
      act_cyc.push_back(cyc);
      act_k.push_back({brk_det, stp_err, par_err, data_valid});
      act_d.push_back(P_DATA);
    end
  end

  logic [DATA_W-1:0] last_good = '0;
  bit                fbits[$];
  int                fP;

  task automatic plan_frame(input int praw, input int lraw,
                            input bit pen, input bit ptyp,
                            input bit st2, input int data,
                            input bit badp, input bit s1v,
                            input bit s2v);
    int L, mid, k;
    logic [DATA_W-1:0] d;
    bit pbit, fin;
    logic [3:0] kind;
    fP = praw & ~1;
    if (fP < 6) fP = 6;
    mid = fP / 2;
    L = (lraw < 5) ? 5 : ((lraw > DATA_W) ? DATA_W : lraw);
    d = DATA_W'(data & ((1 << L) - 1));
    pbit = (^d) ^ ptyp ^ badp;
    fbits.delete();
    fbits.push_back(1'b0);
    for (int i = 0; i < L; i++) fbits.push_back(d[i]);
    if (pen) fbits.push_back(pbit);
    fbits.push_back(s1v);
    if (st2) fbits.push_back(s2v);
    if (st2 && s1v) begin
      k = fbits.size() - 1;
      fin = s2v;
    end else begin
      k = 1 + L + (pen ? 1 : 0);
      fin = s1v;
    end
    if (fin)
      kind = (pen && badp) ? K_PE : K_DV;
    else
      kind = (d == 0 && !(pen && pbit)) ? K_BK : K_SE;
    if (kind == K_DV) last_good = d;
    exp_cyc.push_back(cyc + SYNC + 1 + k * fP + mid + 2);
    exp_k.push_back(kind);
    exp_d.push_back(last_good);
    Prescale = PRESC_W'(praw);
    DATA_LEN = LEN_W'(lraw);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    STOP2    = st2;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive_frame(input int gap);
    for (int i = 0; i < fbits.size(); i++) begin
      RX_IN = fbits[i];
      for (int c = 0; c < fP; c++) begin
        tick(1);
        if (i == 0 && c == 3) begin
          Prescale = PRESC_W'($urandom);
          DATA_LEN = LEN_W'($urandom);
          PAR_EN   = 1'($urandom);
          PAR_TYP  = 1'($urandom);
          STOP2    = 1'($urandom);
        end
      end
    end
    RX_IN = 1'b1;
    tick(gap * fP);
  endtask

  int idx_a5, t_a5, t0;
  logic [7:0] rdat;

  initial begin
    tick(3);
    check("rst_pdata", P_DATA, 0);
    check("rst_flags",
          {brk_det, stp_err, par_err, data_valid}, 0);
    check("rst_busy", busy, 0);
    RST = 1'b0;
    tick(4);

    idx_a5 = exp_cyc.size();
    t_a5 = cyc;
    plan_frame(8, 8, 0, 0, 0, 'hA5, 0, 1, 1);
    drive_frame(2);

    Prescale = 6'd8;
    t0 = cyc;
    RX_IN = 1'b0;
    tick(3);
    RX_IN = 1'b1;
    tick(3);
    check("glitch_busy_hi", busy, 1);
    tick(6);
    check("glitch_busy_lo", busy, 0);
    tick(16);
    plan_frame(8, 8, 0, 0, 0, 'h96, 0, 1, 1);
    drive_frame(2);

    plan_frame(16, 7, 1, 1, 1, 'h3C, 1, 1, 1);
    drive_frame(2);

    plan_frame(8, 8, 0, 0, 0, 'h11, 0, 1, 1);
    drive_frame(0);
    plan_frame(8, 8, 0, 0, 0, 'hEE, 0, 1, 1);
    drive_frame(2);

    plan_frame(8, 8, 1, 0, 0, 0, 0, 0, 1);
    RX_IN = 1'b0;
    tick(160);
    check("brk_busy_hi", busy, 1);
    RX_IN = 1'b1;
    tick(8);
    check("brk_busy_lo", busy, 0);
    tick(8);

    Prescale = 6'd8;
    DATA_LEN = 4'd8;
    PAR_EN = 1'b0;
    STOP2 = 1'b0;
    rdat = 8'h5A;
    RX_IN = 1'b0;
    tick(8);
    for (int i = 0; i < 4; i++) begin
      RX_IN = rdat[i];
      tick(8);
    end
    RX_IN = rdat[4];
    tick(3);
    check("busy_mid", busy, 1);
    RST = 1'b1;
    RX_IN = 1'b1;
    tick(1);
    check("midrst_pdata", P_DATA, 0);
    check("midrst_flags",
          {brk_det, stp_err, par_err, data_valid}, 0);
    check("midrst_busy", busy, 0);
    RST = 1'b0;
    last_good = '0;
    tick(16);
    plan_frame(8, 8, 0, 0, 0, 'h5A, 0, 1, 1);
    drive_frame(2);

    for (int n = 0; n < 40; n++) begin
      int praw, lraw, data, gap;
      bit pen, ptyp, st2, badp, s1v, s2v;
      praw = $urandom_range(0, 31);
      lraw = $urandom_range(0, 15);
      pen  = 1'($urandom);
      ptyp = 1'($urandom);
      st2  = 1'($urandom);
      data = $urandom;
      badp = pen && ($urandom_range(0, 3) == 0);
      s1v  = ($urandom_range(0, 5) != 0);
      s2v  = s1v ? ($urandom_range(0, 5) != 0) : 1'b1;
      if (!s1v && $urandom_range(0, 1) == 1) data = 0;
      if (s1v && (!st2 || s2v)) gap = $urandom_range(0, 2);
      else gap = 2;
      plan_frame(praw, lraw, pen, ptyp, st2,
                 data, badp, s1v, s2v);
      drive_frame(gap);
    end
    tick(100);

    check("n_events", act_cyc.size(), exp_cyc.size());
    for (int i = 0; i < exp_cyc.size() && i < act_cyc.size(); i++) begin
      check($sformatf("ev%0d_cyc", i), act_cyc[i], exp_cyc[i]);
      check($sformatf("ev%0d_kind", i), act_k[i], exp_k[i]);
      check($sformatf("ev%0d_data", i), act_d[i], exp_d[i]);
    end
    check("a5_seen", act_cyc.size() > idx_a5, 1);
    if (act_cyc.size() > idx_a5)
      check("a5_lat", act_cyc[idx_a5] - t_a5, 81);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
